hand_shake_responder: RTL and testbench
=======================================

HAND_SHAKE_RESPONDER -- requirements
Module: hand_shake_responder

Interface
REQ-001 Parameter CAPTURE_WIN, default 4: cycles after ack rise during which instruction is sampled (legal 2..15).
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the captured-command buffer (power of two, 2..16).
REQ-003 Port clk_50MHz  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port req  input  1  request from the initiator, level; held high until ack is seen.
REQ-006 Port instruction  input  3  instruction bus from the initiator; 3'b000 = idle/NOP.
REQ-007 Port ack  output  1  acknowledge to the initiator, registered.
REQ-008 Port cmd  output  3  head-of-buffer command.
REQ-009 Port cmd_valid  output  1  buffer non-empty.
REQ-010 Port cmd_ready  input  1  consumer pop strobe; pop occurs when cmd_valid && cmd_ready.
REQ-011 Port overflow  output  1  sticky flag: a nonzero capture was lost.

Function
REQ-012 FSM states: IDLE, ACK, PUSH, RELEASE; ack=1 only in ACK and PUSH.
REQ-013 IDLE -> ACK when req (post-sync) = 1 and buffer not full; req with buffer full holds IDLE, ack stays 0 (backpressure).
REQ-014 ACK: window counter counts CAPTURE_WIN cycles from 0; each cycle, if no value latched yet and instruction != 0, latch instruction.
REQ-015 ACK -> PUSH when counter reaches CAPTURE_WIN-1.
REQ-016 PUSH (one cycle): if latched value nonzero, write it to buffer; if zero, write nothing; clear latch; go to RELEASE.
REQ-017 RELEASE: ack=0; -> IDLE when req = 0; req still 1 keeps RELEASE (no re-ack of the same request).
REQ-018 Only the first nonzero instruction in a window is kept; later nonzero values in the same window are ignored.
REQ-019 Buffer FIFO order; write and pop in the same cycle both take effect, occupancy unchanged.
REQ-020 Pop on empty buffer ignored; cmd = 3'b000 when cmd_valid = 0.
REQ-021 Write while full (only possible if consumer stalls after IDLE check) is dropped and sets overflow; overflow clears only on rst.
REQ-022 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-023 Latency: ack rises 1 cycle after req sampled high in IDLE; cmd_valid rises 1 cycle after PUSH.

Reset
REQ-024 rst asserted at any time: state IDLE, ack=0, counter 0, latch 0, buffer empty, cmd_valid=0, cmd=0, overflow=0, immediately (asynchronous).
REQ-025 rst mid-handshake discards the in-flight capture; after release the responder waits in IDLE for req=1 (a still-high req is acked anew).

Configuration
REQ-026 Macro HAND_SHAKE_SYNC_EN defined: req and instruction pass through a 2-flop synchronizer (reset to 0) before use; all req-related latencies grow by 2 cycles.
REQ-027 Macro undefined: req and instruction used directly; inputs must be synchronous to clk_50MHz.

Structure
REQ-028 Shared package hand_shake_pkg holds state encoding, INSTR_W=3, NOP code 3'b000.
REQ-029 Buffer implemented as sub-module hs_cmd_fifo (parameter FIFO_DEPTH, ports wr/din/full, rd/dout/empty, overflow).

Verification
REQ-030 rst, req=1, instruction=3'b101 on cycles 2-3 after ack rise -> ack high 5 cycles, cmd_valid=1 with cmd=3'b101, ack=0 then IDLE after req drops.
REQ-031 Window with instruction always 0 -> ack pulse of CAPTURE_WIN+1 cycles, cmd_valid stays 0.
REQ-032 Window with 3'b011 then 3'b110 -> only 3'b011 buffered.
REQ-033 cmd_ready=0, 4 successful handshakes (3'b001..3'b100) -> buffer full, 5th req gets no ack; one pop -> ack issued; pops return 001,010,011,100 in order.
REQ-034 rst pulsed during ACK with 3'b111 latched -> ack=0 same cycle, buffer empty, nothing pushed, overflow=0.
REQ-035 req held high through RELEASE for 10 cycles -> exactly one ack pulse; with HAND_SHAKE_SYNC_EN ack rise delayed 2 extra cycles.

Source files
------------

// File: rtl/hand_shake_pkg.sv
// Shared definitions for the hand-shake responder: instruction width,
// the NOP code, window-counter width and the FSM state encoding.
package hand_shake_pkg;

  localparam int                 INSTR_W = 3;
  localparam logic [INSTR_W-1:0] NOP     = 3'b000;
  // Wide enough for the largest legal capture window (15).
  localparam int                 CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    PUSH    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/hs_cmd_fifo.sv
// Captured-command buffer: a small FIFO with a sticky overflow flag.
// Reads the head combinationally; dout is NOP while empty.
module hs_cmd_fifo
  import hand_shake_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [INSTR_W-1:0] din,
  output logic               full,
  input  logic               rd,
  output logic [INSTR_W-1:0] dout,
  output logic               empty,
  output logic               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign do_rd = rd && !empty;
  // A simultaneous pop frees the slot, so a write on a full buffer then lands.
  assign do_wr = wr && (!full || do_rd);
  assign dout  = empty ? NOP : mem[rd_ptr];

  // Storage array; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth), occupancy and overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && !do_wr) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/hand_shake_responder.sv
// Request/acknowledge responder: acks a req, samples the instruction bus
// for a CAPTURE_WIN-cycle window, keeps the first nonzero value and queues
// it for a downstream consumer.
// Build option: HAND_SHAKE_SYNC_EN adds a 2-flop synchronizer on req and
// instruction (req-related latencies grow by 2 cycles).
module hand_shake_responder
  import hand_shake_pkg::*;
#(
  parameter int CAPTURE_WIN = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               req,
  input  logic [INSTR_W-1:0] instruction,
  output logic               ack,
  output logic [INSTR_W-1:0] cmd,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               overflow
);

  logic               req_s;
  logic [INSTR_W-1:0] instr_s;

`ifdef HAND_SHAKE_SYNC_EN
  logic [1:0]              req_sync;
  logic [1:0][INSTR_W-1:0] instr_sync;

  // Two-stage synchronizer for the initiator-side inputs.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      req_sync   <= '0;
      instr_sync <= '0;
    end else begin
      req_sync   <= {req_sync[0], req};
      instr_sync <= {instr_sync[0], instruction};
    end
  end

  assign req_s   = req_sync[1];
  assign instr_s = instr_sync[1];
`else
  assign req_s   = req;
  assign instr_s = instruction;
`endif

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [INSTR_W-1:0] latch, latch_n;
  logic               ack_n;
  logic               wr, full, empty;

  // State, window counter, capture latch and registered ack.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      latch <= NOP;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      latch <= latch_n;
      ack   <= ack_n;
    end
  end

  // Next-state, window sampling and buffer write decision.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch_n = latch;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        // A full buffer holds off the ack so no capture is taken that cannot be stored.
        if (req_s && !full) begin
          state_n = ACK;
          cnt_n   = '0;
        end
      end
      ACK: begin
        if (latch == NOP && instr_s != NOP) latch_n = instr_s;
        if (cnt == CNT_W'(CAPTURE_WIN-1)) begin
          state_n = PUSH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PUSH: begin
        wr      = (latch != NOP);
        latch_n = NOP;
        state_n = RELEASE;
      end
      RELEASE: begin
        // Wait for req to drop so the same request is not acked twice.
        if (!req_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ack_n = (state_n == ACK) || (state_n == PUSH);
  end

  hs_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk_50MHz),
    .rst      (rst),
    .wr       (wr),
    .din      (latch),
    .full     (full),
    .rd       (cmd_ready),
    .dout     (cmd),
    .empty    (empty),
    .overflow (overflow)
  );

  assign cmd_valid = !empty;

endmodule

// File: tb/tb_hand_shake_responder.sv
// Directed bench for hand_shake_responder with a scoreboard: each handshake
// pushes its expected command; a monitor pops and compares on every accepted pop.
module tb_hand_shake_responder;

  localparam int CW = 4;
  localparam int FD = 4;
`ifdef HAND_SHAKE_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  logic       clk_50MHz = 1'b0;
  logic       rst = 1'b0, req = 1'b0, cmd_ready = 1'b0;
  logic [2:0] instruction = 3'b000;
  logic       ack, cmd_valid, overflow;
  logic [2:0] cmd;

  int         tests = 0, fails = 0;
  logic [2:0] exp_q[$];
  int         mon_exp;

  hand_shake_responder #(.CAPTURE_WIN(CW), .FIFO_DEPTH(FD)) dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .req         (req),
    .instruction (instruction),
    .ack         (ack),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .overflow    (overflow)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are read 3 time units after the rising edge.
  task automatic step();
    @(posedge clk_50MHz);
    #3;
  endtask

  // Scoreboard monitor: compares each accepted pop with the queue head.
  always @(negedge clk_50MHz) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        mon_exp = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : -1;
        chk("pop_cmd", int'(cmd), mon_exp);
      end else if (!cmd_valid) begin
        chk("cmd_zero_when_empty", int'(cmd), 0);
      end
    end
  end

  // One full handshake; w0..w3 are driven on the four window samples.
  task automatic do_hs(input logic [2:0] w0, w1, w2, w3, input int hold,
                       input int exp_lat, input string name);
    logic [2:0] win[4];
    logic [2:0] e;
    bit         was_empty;
    int         lat, n, bad;
    win = '{w0, w1, w2, w3};
    e = 3'b000;
    for (int i = 0; i < 4; i++) if (e == 3'b000 && win[i] != 3'b000) e = win[i];
    was_empty = (exp_q.size() == 0);
    if (e != 3'b000) exp_q.push_back(e);
    req = 1'b1;
    instruction = 3'b000;
    lat = 0;
    while (!ack && lat < 40) begin step(); lat++; end
    chk({name, "_ack_rise"}, int'(ack), 1);
    if (!ack) begin req = 1'b0; return; end
    if (exp_lat >= 0) chk({name, "_ack_latency"}, lat, exp_lat);
    n = 0;
    while (ack && n < 20) begin
      n++;
      instruction = (n <= CW) ? win[n-1] : 3'b000;
      step();
    end
    instruction = 3'b000;
    chk({name, "_ack_len"}, n, CW + 1);
    if (e != 3'b000 && was_empty && !cmd_ready) begin
      chk({name, "_cmd_valid"}, int'(cmd_valid), 1);
      chk({name, "_cmd"}, int'(cmd), int'(e));
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        if (ack) bad++;
        step();
      end
      chk({name, "_no_reack"}, bad, 0);
    end
    req = 1'b0;
    repeat (4) step();
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  initial begin
    int n, bad;
    rst = 1'b1;
    step(); step();
    chk("reset_ack", int'(ack), 0);
    chk("reset_cmd_valid", int'(cmd_valid), 0);
    chk("reset_cmd", int'(cmd), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    step();

    // Basic capture of 101.
    do_hs(3'b000, 3'b101, 3'b101, 3'b000, 0, ACK_LAT, "basic");
    pop_one();
    chk("basic_emptied", int'(cmd_valid), 0);

    // Zero window: nothing buffered.
    do_hs(3'b000, 3'b000, 3'b000, 3'b000, 0, ACK_LAT, "zero_win");
    chk("zero_win_no_cmd", int'(cmd_valid), 0);

    // Only the first nonzero value in a window is kept.
    do_hs(3'b011, 3'b110, 3'b000, 3'b000, 0, ACK_LAT, "first_only");
    pop_one();
    chk("first_only_emptied", int'(cmd_valid), 0);

    // req held through RELEASE: one ack pulse only; capture on last sample.
    do_hs(3'b000, 3'b000, 3'b000, 3'b010, 10, ACK_LAT, "held_req");
    pop_one();

    // Fill the buffer, check backpressure, then release one slot.
    cmd_ready = 1'b0;
    do_hs(3'b001, 3'b000, 3'b000, 3'b000, 0, ACK_LAT, "fill1");
    do_hs(3'b010, 3'b000, 3'b000, 3'b000, 0, ACK_LAT, "fill2");
    do_hs(3'b011, 3'b000, 3'b000, 3'b000, 0, ACK_LAT, "fill3");
    do_hs(3'b100, 3'b000, 3'b000, 3'b000, 0, ACK_LAT, "fill4");
    chk("full_valid", int'(cmd_valid), 1);
    chk("full_head", int'(cmd), 1);
    req = 1'b1;
    bad = 0;
    repeat (8) begin
      if (ack) bad++;
      step();
    end
    chk("full_backpressure", bad, 0);
    pop_one();
    do_hs(3'b101, 3'b000, 3'b000, 3'b000, 0, 1, "after_pop");
    cmd_ready = 1'b1;
    n = 0;
    while (cmd_valid && n < 20) begin step(); n++; end
    cmd_ready = 1'b0;
    chk("drain_empty", int'(cmd_valid), 0);
    chk("no_overflow", int'(overflow), 0);

    // Reset in the middle of a window with 111 latched.
    req = 1'b1;
    n = 0;
    while (!ack && n < 40) begin step(); n++; end
    chk("mid_rst_ack_rise", int'(ack), 1);
    instruction = 3'b111;
    step(); step();
    #4 rst = 1'b1;
    #1;
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_cmd_valid", int'(cmd_valid), 0);
    chk("mid_rst_cmd", int'(cmd), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    instruction = 3'b000;
    step(); step();
    rst = 1'b0;
    // req stayed high through reset: a fresh ack follows.
    do_hs(3'b000, 3'b000, 3'b000, 3'b000, 0, -1, "post_rst");
    chk("post_rst_nothing_pushed", int'(cmd_valid), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
